mux8_rr_sched: RTL

- Round-robin scheduler that shares one 8:1 bit multiplexer among 8 requesting channels.
- Each channel raises a request with a 1-bit payload on its `din` lane. The scheduler picks one winner, drives the mux select, and registers the selected bit.
- The registered bit is presented downstream through a valid/ready handshake, tagged with the channel index.
- Sits between the per-channel bit sources and the serial consumer of the shared mux output.

---
 rtl/mux8_sched_pkg.sv | 46 ++++
 rtl/mux8.sv | 17 +
 rtl/mux8_rr_sched.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mux8_sched_pkg.sv
// mux8_sched_pkg
// Shared constants, FSM state type and the round-robin pick helper for the
// mux8_rr_sched scheduler.
// Optional feature macro: MUX8_SCHED_BURST_EN (adds MAX_BURST and the burst
// counter width).
package mux8_sched_pkg;

  localparam int NCH  = 8;   // number of channels (fixed)
  localparam int SELW = 3;   // select width, log2(NCH)

`ifdef MUX8_SCHED_BURST_EN
  localparam int MAX_BURST = 4;  // max consecutive beats per channel, 1..15
  localparam int BCW       = 4;  // burst counter width
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    OUT    = 2'd2
  } state_t;

  typedef struct packed {
    logic            found;
    logic [SELW-1:0] idx;
  } pick_t;

  // Round-robin search starting just after ptr. Scanning from the farthest
  // candidate back to the nearest lets the nearest requester overwrite the
  // result, so no early exit is needed.
  function automatic pick_t rr_pick(input logic [NCH-1:0]  req_v,
                                    input logic [SELW-1:0] ptr_v);
    pick_t           res;
    logic [SELW-1:0] cand;
    res.found = 1'b0;
    res.idx   = ptr_v;
    for (int k = NCH; k >= 1; k--) begin
      cand = ptr_v + SELW'(k);
      if (req_v[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux8.sv
// mux8
// Combinational 8:1 single-bit multiplexer shared by all channels.
// Ports:
//   din [7:0] in  - per-channel data bits
//   s   [2:0] in  - select
//   y         out - din[s]
module mux8
  import mux8_sched_pkg::*;
(
  input  logic [NCH-1:0]  din,
  input  logic [SELW-1:0] s,
  output logic            y
);

  assign y = din[s];

endmodule

// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched
// Round-robin scheduler sharing one 8:1 bit mux among 8 requesting channels.
// A winner is chosen in IDLE, its bit is captured in SAMPLE (with a one-cycle
// ack pulse) and presented downstream in OUT until accepted.
// Optional feature macro: MUX8_SCHED_BURST_EN - lets the current owner keep
// the mux for up to MAX_BURST consecutive beats, skipping IDLE.
// Ports:
//   clk          in  - rising-edge clock
//   rst          in  - synchronous reset, active-high
//   req   [7:0]  in  - per-channel request
//   din   [7:0]  in  - per-channel payload bit, valid while req[i]=1
//   ack   [7:0]  out - one-hot, one-cycle pulse: channel's bit consumed
//   sel   [2:0]  out - mux select currently applied
//   y            out - registered selected bit
//   y_chan[2:0]  out - channel index of y
//   y_valid      out - y/y_chan valid
//   y_ready      in  - downstream accept
//   busy         out - scheduler not idle
module mux8_rr_sched
  import mux8_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  input  logic [NCH-1:0]  din,
  output logic [NCH-1:0]  ack,
  output logic [SELW-1:0] sel,
  output logic            y,
  output logic [SELW-1:0] y_chan,
  output logic            y_valid,
  input  logic            y_ready,
  output logic            busy
);

  state_t          state_r;
  state_t          state_n_s;
  logic [SELW-1:0] ptr_r;
  logic [SELW-1:0] sel_r;
  logic            y_r;
  logic [SELW-1:0] y_chan_r;
  logic            y_valid_r;
  logic [NCH-1:0]  ack_r;
  logic            mux_y_s;
  pick_t           pick_s;
  logic            load_sel_s;
  logic            sample_s;
  logic            release_s;
`ifdef MUX8_SCHED_BURST_EN
  logic [BCW-1:0]  burst_r;
  logic            burst_inc_s;
  logic            burst_clr_s;
`endif

  mux8 u_mux8 (
    .din (din),
    .s   (sel_r),
    .y   (mux_y_s)
  );

  // Next-state and control decode for the IDLE/SAMPLE/OUT sequence.
  always_comb begin
    pick_s     = rr_pick(req, ptr_r);
    state_n_s  = state_r;
    load_sel_s = 1'b0;
    sample_s   = 1'b0;
    release_s  = 1'b0;
`ifdef MUX8_SCHED_BURST_EN
    burst_inc_s = 1'b0;
    burst_clr_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (pick_s.found) begin
          state_n_s  = SAMPLE;
          load_sel_s = 1'b1;
        end else begin
          state_n_s  = IDLE;
        end
      end
      SAMPLE: begin
        // Capture is committed regardless of req[sel] in this cycle.
        sample_s  = 1'b1;
        state_n_s = OUT;
      end
      OUT: begin
        if (y_valid_r && y_ready) begin
          release_s = 1'b1;
`ifdef MUX8_SCHED_BURST_EN
          // ptr equals sel here, so req[ptr] is the current owner still asking.
          if (req[ptr_r] && (({1'b0, burst_r} + 5'd1) < 5'(MAX_BURST))) begin
            state_n_s   = SAMPLE;
            burst_inc_s = 1'b1;
          end else begin
            state_n_s   = IDLE;
            burst_clr_s = 1'b1;
          end
`else
          state_n_s = IDLE;
`endif
        end else begin
          state_n_s = OUT;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Grant bookkeeping: applied select and last-grant pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r <= {SELW{1'b0}};
      ptr_r <= SELW'(NCH - 1);
    end else begin
      if (load_sel_s) begin
        sel_r <= pick_s.idx;
      end
      if (sample_s) begin
        ptr_r <= sel_r;
      end
    end
  end

  // Downstream output register and ack pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r       <= 1'b0;
      y_chan_r  <= {SELW{1'b0}};
      y_valid_r <= 1'b0;
      ack_r     <= {NCH{1'b0}};
    end else begin
      ack_r <= sample_s ? ({{(NCH-1){1'b0}}, 1'b1} << sel_r) : {NCH{1'b0}};
      if (sample_s) begin
        y_r       <= mux_y_s;
        y_chan_r  <= sel_r;
        y_valid_r <= 1'b1;
      end else if (release_s) begin
        y_valid_r <= 1'b0;
      end
    end
  end

`ifdef MUX8_SCHED_BURST_EN
  // Consecutive-beat counter for the current owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_r <= {BCW{1'b0}};
    end else if (burst_clr_s) begin
      burst_r <= {BCW{1'b0}};
    end else if (burst_inc_s) begin
      burst_r <= burst_r + {{(BCW-1){1'b0}}, 1'b1};
    end
  end
`endif

  assign ack     = ack_r;
  assign sel     = sel_r;
  assign y       = y_r;
  assign y_chan  = y_chan_r;
  assign y_valid = y_valid_r;
  assign busy    = (state_r != IDLE);

endmodule
